// File: rtl/demux_dest.sv
// demux_dest: two-stage capture/route of popped VC words into destination FIFOs D0/D1.
// Optional feature macro: DEST_COUNT_EN adds saturating per-destination push counters.
module demux_dest #(
    parameter int BW       = 6,
    parameter int DEST_BIT = 4,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             vc0_read,
    input  logic             vc1_read,
    input  logic [BW-1:0]    vc0_data_out,
    input  logic [BW-1:0]    vc1_data_out,
    input  logic             d0_full,
    input  logic             d1_full,
    output logic             d0_push,
    output logic [BW-1:0]    d0_data_in,
    output logic             d1_push,
    output logic [BW-1:0]    d1_data_in,
    output logic             error_out
`ifdef DEST_COUNT_EN
    ,
    output logic [CNT_W-1:0] d0_count,
    output logic [CNT_W-1:0] d1_count
`endif
);
    logic          rd0_q, rd1_q;
    logic          sel_valid_q, sel_valid_d;
    logic [BW-1:0] sel_data_q, sel_data_d;
    logic          d0_push_q, d0_push_d, d1_push_q, d1_push_d;
    logic [BW-1:0] d0_data_q, d0_data_d, d1_data_q, d1_data_d;
    logic          err_q, err_d;
    logic          dest, drop;

    // Next state: select the popped word, then route it unless its target is full.
    // A simultaneous pop of both VCs is flagged as soon as the strobes are seen.
    always_comb begin
        sel_valid_d = rd0_q | rd1_q;
        sel_data_d  = rd0_q ? vc0_data_out : vc1_data_out;
        dest        = sel_data_q[DEST_BIT];
        d0_push_d   = sel_valid_q & ~dest & ~d0_full;
        d1_push_d   = sel_valid_q & dest & ~d1_full;
        drop        = sel_valid_q & (dest ? d1_full : d0_full);
        d0_data_d   = d0_push_d ? sel_data_q : d0_data_q;
        d1_data_d   = d1_push_d ? sel_data_q : d1_data_q;
        err_d       = err_q | (vc0_read & vc1_read) | drop;
    end

    // Pipeline and output registers; reset flushes every in-flight word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rd0_q       <= 1'b0;
            rd1_q       <= 1'b0;
            sel_valid_q <= 1'b0;
            sel_data_q  <= '0;
            d0_push_q   <= 1'b0;
            d1_push_q   <= 1'b0;
            d0_data_q   <= '0;
            d1_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            rd0_q       <= vc0_read;
            rd1_q       <= vc1_read;
            sel_valid_q <= sel_valid_d;
            sel_data_q  <= sel_data_d;
            d0_push_q   <= d0_push_d;
            d1_push_q   <= d1_push_d;
            d0_data_q   <= d0_data_d;
            d1_data_q   <= d1_data_d;
            err_q       <= err_d;
        end
    end

    assign d0_push    = d0_push_q;
    assign d1_push    = d1_push_q;
    assign d0_data_in = d0_data_q;
    assign d1_data_in = d1_data_q;
    assign error_out  = err_q;

`ifdef DEST_COUNT_EN
    logic [CNT_W-1:0] d0_cnt_q, d0_cnt_d, d1_cnt_q, d1_cnt_d;

    // Counters follow the issued pushes and stick at all-ones.
    always_comb begin
        d0_cnt_d = (d0_push_d && d0_cnt_q != '1) ? d0_cnt_q + CNT_W'(1) : d0_cnt_q;
        d1_cnt_d = (d1_push_d && d1_cnt_q != '1) ? d1_cnt_q + CNT_W'(1) : d1_cnt_q;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            d0_cnt_q <= '0;
            d1_cnt_q <= '0;
        end else begin
            d0_cnt_q <= d0_cnt_d;
            d1_cnt_q <= d1_cnt_d;
        end
    end

    assign d0_count = d0_cnt_q;
    assign d1_count = d1_cnt_q;
`endif
endmodule
